hazard_flush_ctrl: RTL and testbench
====================================

# hazard_flush_ctrl

- Generates the flush and freeze controls consumed by the pipeline stage registers, including the ID/EX register's `flush` input.
- Detects three conditions:
  - load-use RAW hazards between the instruction in ID and the load in EXE;
  - taken branches resolved in EXE;
  - multicycle data-memory accesses in MEM.
- Holds a small FSM and counter that freezes the whole pipeline for the memory wait time, plus a saturating stall-cycle counter for debug.

## Interface

Parameters:
- `MEM_WAIT`, 5: number of freeze cycles per data-memory access; must be at least 1.
- `STALL_CNT_W`, 16: width of the stall statistics counter.

Ports:
- `clk`  in  1  the single pipeline clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset, sampled on the rising edge of `clk`.
- `id_src1`  in  5  rs of the instruction in ID.
- `id_src2`  in  5  rt of the instruction in ID.
- `id_two_src`  in  1  the ID instruction actually reads `id_src2`.
- `exe_dest`  in  5  destination of the instruction in EXE (ID/EX register output).
- `exe_wb_en`  in  1  the EXE instruction writes back.
- `exe_mem_r_en`  in  1  the EXE instruction is a load.
- `mem_dest`  in  5  destination of the instruction in MEM.
- `mem_wb_en`  in  1  the MEM instruction writes back.
- `br_taken`  in  1  branch resolved taken in EXE.
- `mem_req`  in  1  MEM-stage instruction performs a load or store.
- `freeze_pc`  out  1  hold the PC.
- `freeze_if_id`  out  1  hold the IF/ID register.
- `flush_if_id`  out  1  clear the IF/ID register.
- `flush_id_ex`  out  1  clear the ID/EX register (bubble insertion).
- `pipe_freeze`  out  1  hold every stage register, including ID/EX, EX/MEM and MEM/WB.
- `mem_done`  out  1  one-cycle pulse on the last cycle of a memory access.
- `stall_cycles`  out  `STALL_CNT_W`  saturating count of cycles with `freeze_pc` high.

## Operation

- FSM states:
  - `IDLE`: no access in progress.
  - `WAIT`: counter `cnt` is active.
- Memory-wait sequence:
  - In `IDLE` with `mem_req=1`: `pipe_freeze=1`, load `cnt<=MEM_WAIT-1`, next state is `WAIT`.
  - In `WAIT` with `cnt!=0`: `pipe_freeze=1`, `cnt<=cnt-1`.
  - In `WAIT` with `cnt==0`: `pipe_freeze=0`, `mem_done=1`, next state is `IDLE`.
  - `mem_req` is ignored while in `WAIT`. In the `cnt==0` cycle it still belongs to the same instruction and must not retrigger.
- Load-use hazard (`lu`) is true when all of the following hold:
  - `exe_mem_r_en`, `exe_wb_en` and `exe_dest!=0`;
  - `exe_dest==id_src1`, or `id_two_src` and `exe_dest==id_src2`.
- Register 0 never causes a hazard.
- Priority, highest first:
  1. `pipe_freeze` suppresses everything else: the flush and stall outputs are 0 and retained conditions re-evaluate once the freeze drops.
  2. `br_taken`: `flush_if_id=1` and `flush_id_ex=1`; `freeze_pc` and `freeze_if_id` are 0, so the PC loads the branch target.
  3. `lu`: `freeze_pc=1`, `freeze_if_id=1`, `flush_id_ex=1`.
- `freeze_pc` is also 1 whenever `pipe_freeze=1`. `freeze_if_id` follows `freeze_pc`.
- `stall_cycles` increments each cycle `freeze_pc=1` and saturates at all-ones.
- All outputs are combinational from the state and inputs, except `stall_cycles`, which is registered.

## Timing

- Reset: while `rst=1`, every combinational output is forced to 0. After the edge: state `IDLE`, `cnt=0`, `stall_cycles=0`.
- Reset during `WAIT` aborts the access; no `mem_done` is generated.
- Branch and load-use responses have zero-cycle latency: outputs are valid in the same cycle as the cause and are applied by stage registers on the next edge.
- A `mem_req` first seen at cycle t gives:
  - `pipe_freeze` high in cycles t through t+MEM_WAIT-1, which is exactly `MEM_WAIT` cycles;
  - `mem_done` and `pipe_freeze=0` at cycle t+MEM_WAIT;
  - the earliest retrigger at t+MEM_WAIT+1.
- `MEM_WAIT=1`: one freeze cycle, then a `mem_done` cycle.
- `br_taken` together with `lu`: only the flush is issued and there is no stall.
- `br_taken` together with `mem_req` in `IDLE`: the freeze wins. The flush is issued at t+MEM_WAIT, when `br_taken` is still held.

## Configuration

- `HAZARD_FORWARDING_EN` defined: hazard detection is load-use only, as above, relying on the forwarding unit.
- Undefined (no forwarding): the hazard condition additionally stalls on any RAW against EXE with `exe_wb_en` (load or ALU), or against MEM with `mem_wb_en` and `mem_dest!=0`. The stall action and priority are the same as for `lu`.

## Structure

- Package `hazard_pkg` holds:
  - the FSM state encoding (`IDLE`, `WAIT`);
  - `REG_IDX_W=5`;
  - the default `MEM_WAIT`.
- Sub-module `mem_wait_fsm` holds the state, `cnt`, `pipe_freeze` and `mem_done`.
- The top level holds the hazard comparators, the priority logic and `stall_cycles`.

## Test plan

- Reset: drive `rst=1` with `mem_req=1` and `br_taken=1` -> all outputs 0. After release, `stall_cycles=0`.
- Load-use: `exe_mem_r_en=1`, `exe_wb_en=1`, `exe_dest=8`, `id_src1=8` -> `freeze_pc`, `freeze_if_id` and `flush_id_ex` high for 1 cycle. Repeat with `exe_dest=0` -> no stall.
- Branch: `br_taken=1` with load-use active -> `flush_if_id=flush_id_ex=1` and `freeze_pc=0`.
- Memory wait: `MEM_WAIT=5`, `mem_req` held for 6 cycles -> `pipe_freeze` high for exactly 5 cycles, then `mem_done` for 1 cycle, no retrigger. A new `mem_req` the next cycle restarts the sequence.
- Reset during `WAIT` at `cnt=2` -> outputs 0 immediately, state `IDLE`, no `mem_done`.
- Without `HAZARD_FORWARDING_EN`: ALU op in MEM with `mem_dest=3` and `id_src2=3`, `id_two_src=1` -> stall. With the macro defined -> no stall. `stall_cycles` saturates at `2^STALL_CNT_W-1` under a forced continuous stall (use `STALL_CNT_W=4`).

Source files
------------

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types, widths and helpers for hazard_flush_ctrl
package hazard_pkg;

    localparam int REG_IDX_W    = 5;
    localparam int MEM_WAIT_DEF = 5;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mw_state_e;

    // Register 0 is hardwired, so it never produces a dependency.
    function automatic logic src_match(
        input logic [REG_IDX_W-1:0] dest,
        input logic [REG_IDX_W-1:0] src1,
        input logic [REG_IDX_W-1:0] src2,
        input logic                 two_src
    );
        return (dest != '0) && ((dest == src1) || (two_src && (dest == src2)));
    endfunction

endpackage

// File: rtl/mem_wait_fsm.sv
// rtl/mem_wait_fsm.sv - freezes the pipeline for MEM_WAIT cycles per data-memory access
module mem_wait_fsm
    import hazard_pkg::*;
#(
    parameter int MEM_WAIT = MEM_WAIT_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_mem_req,
    output logic o_pipe_freeze,
    output logic o_mem_done
);

    localparam int CNT_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;

    mw_state_e        r_state;
    mw_state_e        w_nxt_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_nxt_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
        end
    end

    // mem_req is not looked at in WAIT: the done cycle still belongs to the same access.
    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_cnt     = r_cnt;
        o_pipe_freeze = 1'b0;
        o_mem_done    = 1'b0;
        if (!i_rst) begin
            case (r_state)
                IDLE: begin
                    if (i_mem_req) begin
                        o_pipe_freeze = 1'b1;
                        w_nxt_cnt     = CNT_W'(MEM_WAIT - 1);
                        w_nxt_state   = WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt != '0) begin
                        o_pipe_freeze = 1'b1;
                        w_nxt_cnt     = r_cnt - CNT_W'(1);
                    end else begin
                        o_mem_done  = 1'b1;
                        w_nxt_state = IDLE;
                    end
                end
                default: w_nxt_state = IDLE;
            endcase
        end
    end

endmodule

// File: rtl/hazard_flush_ctrl.sv
// rtl/hazard_flush_ctrl.sv - pipeline flush/freeze control; HAZARD_FORWARDING_EN limits stalls to load-use
module hazard_flush_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_WAIT    = MEM_WAIT_DEF,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [REG_IDX_W-1:0]   id_src1,
    input  logic [REG_IDX_W-1:0]   id_src2,
    input  logic                   id_two_src,
    input  logic [REG_IDX_W-1:0]   exe_dest,
    input  logic                   exe_wb_en,
    input  logic                   exe_mem_r_en,
    input  logic [REG_IDX_W-1:0]   mem_dest,
    input  logic                   mem_wb_en,
    input  logic                   br_taken,
    input  logic                   mem_req,
    output logic                   freeze_pc,
    output logic                   freeze_if_id,
    output logic                   flush_if_id,
    output logic                   flush_id_ex,
    output logic                   pipe_freeze,
    output logic                   mem_done,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    logic                   w_lu;
    logic                   w_hazard;
    logic [STALL_CNT_W-1:0] r_stall_cycles;

    mem_wait_fsm #(
        .MEM_WAIT (MEM_WAIT)
    ) u_mem_wait_fsm (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_mem_req     (mem_req),
        .o_pipe_freeze (pipe_freeze),
        .o_mem_done    (mem_done)
    );

    assign w_lu = exe_mem_r_en && exe_wb_en
               && src_match(exe_dest, id_src1, id_src2, id_two_src);

`ifdef HAZARD_FORWARDING_EN
    assign w_hazard = w_lu;
`else
    // Without forwarding every in-flight writer of a source register must retire first.
    assign w_hazard = w_lu
                   || (exe_wb_en && src_match(exe_dest, id_src1, id_src2, id_two_src))
                   || (mem_wb_en && src_match(mem_dest, id_src1, id_src2, id_two_src));
`endif

    always_comb begin
        freeze_pc   = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        if (rst) begin
            freeze_pc = 1'b0;
        end else if (pipe_freeze) begin
            freeze_pc = 1'b1;
        end else if (br_taken) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end else if (w_hazard) begin
            freeze_pc   = 1'b1;
            flush_id_ex = 1'b1;
        end
        freeze_if_id = freeze_pc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (freeze_pc && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + STALL_CNT_W'(1);
        end
    end

    assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// tb/tb_hazard_flush_ctrl.sv - directed table-driven bench for hazard_flush_ctrl
module tb_hazard_flush_ctrl;

    localparam int MW = 5;
    localparam int SW = 4;
    localparam int SAT = (1 << SW) - 1;
`ifdef HAZARD_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    id_src1, id_src2, exe_dest, mem_dest;
    logic          id_two_src, exe_wb_en, exe_mem_r_en, mem_wb_en, br_taken, mem_req;
    logic          freeze_pc, freeze_if_id, flush_if_id, flush_id_ex, pipe_freeze, mem_done;
    logic [SW-1:0] stall_cycles;

    int n_pass = 0;
    int n_tot  = 0;
    int exp_stall = 0;

    hazard_flush_ctrl #(
        .MEM_WAIT    (MW),
        .STALL_CNT_W (SW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_two_src   (id_two_src),
        .exe_dest     (exe_dest),
        .exe_wb_en    (exe_wb_en),
        .exe_mem_r_en (exe_mem_r_en),
        .mem_dest     (mem_dest),
        .mem_wb_en    (mem_wb_en),
        .br_taken     (br_taken),
        .mem_req      (mem_req),
        .freeze_pc    (freeze_pc),
        .freeze_if_id (freeze_if_id),
        .flush_if_id  (flush_if_id),
        .flush_id_ex  (flush_id_ex),
        .pipe_freeze  (pipe_freeze),
        .mem_done     (mem_done),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic [4:0] s1;
        logic [4:0] s2;
        logic       two;
        logic [4:0] ed;
        logic       ewb;
        logic       erd;
        logic [4:0] md;
        logic       mwb;
        logic       br;
        logic [2:0] exp_fwd;
        logic [2:0] exp_nofwd;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Check all outputs at the negedge, then advance one clock and update the stall model.
    task automatic cyc(input string nm, input bit e_fpc, input bit e_flif, input bit e_flex,
                       input bit e_pf, input bit e_md);
        @(negedge clk);
        chk({nm, ".freeze_pc"},    {31'd0, freeze_pc},    {31'd0, e_fpc});
        chk({nm, ".freeze_if_id"}, {31'd0, freeze_if_id}, {31'd0, e_fpc});
        chk({nm, ".flush_if_id"},  {31'd0, flush_if_id},  {31'd0, e_flif});
        chk({nm, ".flush_id_ex"},  {31'd0, flush_id_ex},  {31'd0, e_flex});
        chk({nm, ".pipe_freeze"},  {31'd0, pipe_freeze},  {31'd0, e_pf});
        chk({nm, ".mem_done"},     {31'd0, mem_done},     {31'd0, e_md});
        chk({nm, ".stall_cycles"}, {28'd0, stall_cycles}, exp_stall);
        @(posedge clk);
        if (rst) exp_stall = 0;
        else if (e_fpc && exp_stall < SAT) exp_stall++;
        #1;
    endtask

    task automatic clear_inputs();
        id_src1 = 0; id_src2 = 0; id_two_src = 0;
        exe_dest = 0; exe_wb_en = 0; exe_mem_r_en = 0;
        mem_dest = 0; mem_wb_en = 0; br_taken = 0; mem_req = 0;
    endtask

    initial begin
        // expected bits: {freeze_pc, flush_if_id, flush_id_ex}
        vecs[0]  = '{"lu_src1",      8, 0, 0, 8, 1, 1, 0, 0, 0, 3'b101, 3'b101};
        vecs[1]  = '{"lu_r0",        0, 0, 0, 0, 1, 1, 0, 0, 0, 3'b000, 3'b000};
        vecs[2]  = '{"br_over_lu",   8, 0, 0, 8, 1, 1, 0, 0, 1, 3'b011, 3'b011};
        vecs[3]  = '{"lu_src2",      1, 9, 1, 9, 1, 1, 0, 0, 0, 3'b101, 3'b101};
        vecs[4]  = '{"src2_unused",  1, 9, 0, 9, 1, 1, 0, 0, 0, 3'b000, 3'b000};
        vecs[5]  = '{"alu_exe_raw",  4, 0, 0, 4, 1, 0, 0, 0, 0, 3'b000, 3'b101};
        vecs[6]  = '{"alu_mem_raw",  1, 3, 1, 0, 0, 0, 3, 1, 0, 3'b000, 3'b101};
        vecs[7]  = '{"mem_r0",       0, 0, 1, 0, 0, 0, 0, 1, 0, 3'b000, 3'b000};
        vecs[8]  = '{"load_no_wb",   6, 0, 0, 6, 0, 1, 0, 0, 0, 3'b000, 3'b000};
        vecs[9]  = '{"br_only",      0, 0, 0, 0, 0, 0, 0, 0, 1, 3'b011, 3'b011};
        vecs[10] = '{"idle",         2, 5, 1, 7, 1, 1, 9, 1, 0, 3'b000, 3'b000};
        vecs[11] = '{"br_over_mem",  1, 3, 1, 0, 0, 0, 3, 1, 1, 3'b011, 3'b011};

        // Reset with every trigger asserted.
        clear_inputs();
        rst = 1; mem_req = 1; br_taken = 1;
        exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = 8; id_src1 = 8;
        @(posedge clk); #1;
        cyc("reset", 0, 0, 0, 0, 0);
        clear_inputs();
        rst = 0;
        cyc("post_reset", 0, 0, 0, 0, 0);

        for (int i = 0; i < 12; i++) begin
            logic [2:0] e;
            e = FWD ? vecs[i].exp_fwd : vecs[i].exp_nofwd;
            id_src1 = vecs[i].s1; id_src2 = vecs[i].s2; id_two_src = vecs[i].two;
            exe_dest = vecs[i].ed; exe_wb_en = vecs[i].ewb; exe_mem_r_en = vecs[i].erd;
            mem_dest = vecs[i].md; mem_wb_en = vecs[i].mwb; br_taken = vecs[i].br;
            mem_req = 0;
            cyc(vecs[i].nm, e[2], e[1], e[0], 0, 0);
        end
        clear_inputs();

        // mem_req held six cycles: five freeze cycles, one done cycle, no retrigger.
        mem_req = 1;
        for (int i = 0; i < MW; i++) cyc("memwait", 1, 0, 0, 1, 0);
        cyc("memdone", 0, 0, 0, 0, 1);
        mem_req = 0;
        cyc("no_retrigger", 0, 0, 0, 0, 0);

        // Branch held across an access: freeze wins, flush lands on the done cycle.
        mem_req = 1; br_taken = 1;
        for (int i = 0; i < MW; i++) cyc("mem_br_wait", 1, 0, 0, 1, 0);
        cyc("mem_br_done", 0, 1, 1, 0, 1);
        clear_inputs();

        // Back-to-back restart right after done.
        mem_req = 1;
        for (int i = 0; i < MW; i++) cyc("memwait2", 1, 0, 0, 1, 0);
        cyc("memdone2", 0, 0, 0, 0, 1);
        cyc("restart", 1, 0, 0, 1, 0);
        mem_req = 0;
        for (int i = 1; i < MW; i++) cyc("restart_wait", 1, 0, 0, 1, 0);
        cyc("restart_done", 0, 0, 0, 0, 1);

        // Reset while WAIT has cnt==2 aborts the access.
        mem_req = 1;
        for (int i = 0; i < 3; i++) cyc("pre_abort", 1, 0, 0, 1, 0);
        rst = 1;
        cyc("abort_rst", 0, 0, 0, 0, 0);
        rst = 0; mem_req = 0;
        for (int i = 0; i < MW; i++) cyc("after_abort", 0, 0, 0, 0, 0);

        // Continuous load-use stall saturates the 4-bit counter.
        exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = 12; id_src1 = 12;
        for (int i = 0; i < SAT + 4; i++) cyc("saturate", 1, 0, 1, 0, 0);
        @(negedge clk);
        chk("sat_final", {28'd0, stall_cycles}, SAT);
        clear_inputs();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
